// File: rtl/debounce_pkg.sv
// debounce_pkg: FSM state type and parameter defaults shared by the button debouncer.
package debounce_pkg;
  typedef enum logic [1:0] {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} state_t;
  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEF_CNT_W           = 4;
  function automatic int unsigned cnt_width(input int unsigned d);
    return $clog2(d + 1);
  endfunction
endpackage

// File: rtl/btn_debounce_sync_chain.sv
// sync_chain: multi-flop synchronizer for an asynchronous single-bit input.
module sync_chain
  import debounce_pkg::*;
#(
  parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_chain;
  always_ff @(posedge clk)
    r_chain <= !resetn ? '0 : {r_chain[STAGES-2:0], i_d};
  assign o_q = r_chain[STAGES-1];
endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: synchronized, debounced button level with rise/fall pulses and press count.
// Optional DEBOUNCE_TOGGLE_EN adds a toggle register flipped on every accepted rise.
module btn_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_raw,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] press_cnt,
  output logic             toggle
);
  localparam int unsigned   CW     = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam bit            BYPASS = DEBOUNCE_CYCLES == 1;
  logic             w_sync;
  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_level, r_rise, r_fall, w_rise_nxt, w_fall_nxt;
  logic [CNT_W-1:0] r_press;
  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .i_d    (in_raw),
    .o_q    (w_sync)
  );
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE_LO;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
  // r_cnt holds samples already seen; the current matching sample completes the run at C_LAST
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      IDLE_LO: if (w_sync) begin
        w_state_nxt = BYPASS ? IDLE_HI : WAIT_HI;
        w_cnt_nxt   = BYPASS ? '0 : C_ONE;
      end
      WAIT_HI:
        if (!w_sync) w_state_nxt = IDLE_LO;
        else if (r_cnt == C_LAST) w_state_nxt = IDLE_HI;
        else w_cnt_nxt = r_cnt + C_ONE;
      IDLE_HI: if (!w_sync) begin
        w_state_nxt = BYPASS ? IDLE_LO : WAIT_LO;
        w_cnt_nxt   = BYPASS ? '0 : C_ONE;
      end
      WAIT_LO:
        if (w_sync) w_state_nxt = IDLE_HI;
        else if (r_cnt == C_LAST) w_state_nxt = IDLE_LO;
        else w_cnt_nxt = r_cnt + C_ONE;
      default: w_state_nxt = IDLE_LO;
    endcase
  end
  always_comb begin
    w_rise_nxt = (w_state_nxt == IDLE_HI) && !r_level;
    w_fall_nxt = (w_state_nxt == IDLE_LO) && r_level;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_press <= '0;
    end else begin
      r_level <= w_rise_nxt ? 1'b1 : w_fall_nxt ? 1'b0 : r_level;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_press <= r_press + CNT_W'(w_rise_nxt);
    end
  end
`ifdef DEBOUNCE_TOGGLE_EN
  logic r_toggle;
  always_ff @(posedge clk)
    r_toggle <= !resetn ? 1'b0 : r_toggle ^ w_rise_nxt;
  assign toggle = r_toggle;
`else
  assign toggle = 1'b0;
`endif
  assign level     = r_level;
  assign rise      = r_rise;
  assign fall      = r_fall;
  assign press_cnt = r_press;
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: table vectors, directed corner sequences and randomized runs against a sliding-window model.
module tb_btn_debounce;
  localparam int S = 2;
  localparam int D = 4;
  localparam int W = 4;
  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         in_raw = 1'b0;
  logic         level, rise, fall, toggle;
  logic [W-1:0] press_cnt;
  int tests = 0;
  int fails = 0;
  bit m_hist[$];
  bit m_lvl, m_rise, m_fall, m_tog;
  int m_cnt;
  typedef struct {bit rn; bit raw; int lvl; int rs; int fl; int cnt;} vec_t;
  vec_t tbl[30];
  btn_debounce #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .CNT_W(W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_raw    (in_raw),
    .level     (level),
    .rise      (rise),
    .fall      (fall),
    .press_cnt (press_cnt),
    .toggle    (toggle)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Level flips when the last D synchronized samples all disagree with it; reset acts as a run of zero samples.
  task automatic model_edge();
    bit all_diff;
    int last;
    if (!resetn) begin
      m_hist.delete();
      for (int i = 0; i < S + D; i++) m_hist.push_back(1'b0);
      {m_lvl, m_rise, m_fall, m_tog} = '0;
      m_cnt = 0;
    end else begin
      m_hist.push_back(in_raw);
      if (m_hist.size() > S + D + 2) void'(m_hist.pop_front());
      last = m_hist.size() - 1 - S;
      all_diff = 1'b1;
      for (int j = 0; j < D; j++) if (m_hist[last - j] == m_lvl) all_diff = 1'b0;
      m_rise = all_diff && !m_lvl;
      m_fall = all_diff && m_lvl;
      if (all_diff) m_lvl = !m_lvl;
      if (m_rise) begin
        m_cnt = (m_cnt + 1) % (1 << W);
        m_tog = !m_tog;
      end
    end
  endtask
  task automatic step(input bit rn, input bit raw);
    @(negedge clk);
    resetn = rn;
    in_raw = raw;
    @(posedge clk);
    model_edge();
    #1;
    chk("model_level", int'(level), int'(m_lvl));
    chk("model_rise", int'(rise), int'(m_rise));
    chk("model_fall", int'(fall), int'(m_fall));
    chk("model_press_cnt", int'(press_cnt), m_cnt);
    chk("rise_fall_exclusive", int'(rise && fall), 0);
`ifdef DEBOUNCE_TOGGLE_EN
    chk("model_toggle", int'(toggle), int'(m_tog));
`else
    chk("model_toggle", int'(toggle), 0);
`endif
  endtask
  task automatic do_reset();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask
  task automatic press();
    int nf;
    nf = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0);
      nf += int'(fall);
    end
    chk("fall_per_release", nf, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int k;
    for (int i = 0; i < 30; i++) begin
      tbl[i].rn  = i >= 2;
      tbl[i].raw = i >= 10 && i < 18;
      tbl[i].lvl = (i >= 15 && i < 23) ? 1 : 0;
      tbl[i].rs  = i == 15 ? 1 : 0;
      tbl[i].fl  = i == 23 ? 1 : 0;
      tbl[i].cnt = i >= 15 ? 1 : 0;
    end
    for (int i = 0; i < 30; i++) begin
      step(tbl[i].rn, tbl[i].raw);
      chk("tbl_level", int'(level), tbl[i].lvl);
      chk("tbl_rise", int'(rise), tbl[i].rs);
      chk("tbl_fall", int'(fall), tbl[i].fl);
      chk("tbl_press_cnt", int'(press_cnt), tbl[i].cnt);
    end
    do_reset();
    for (int i = 0; i < 13; i++) begin
      step(1'b1, i < 3);
      chk("glitch_quiet", int'(level | rise | fall), 0);
    end
    chk("glitch_press_cnt", int'(press_cnt), 0);
    do_reset();
    for (int p = 1; p <= 17; p++) begin
      press();
      if (p == 15) chk("wrap_cnt_15", int'(press_cnt), 15);
      if (p == 16) chk("wrap_cnt_0", int'(press_cnt), 0);
      if (p == 17) chk("wrap_cnt_1", int'(press_cnt), 1);
    end
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk("rst_wait_outputs", int'({level, rise, fall, toggle, press_cnt}), 0);
    k = -1;
    for (int i = 1; i <= 12 && k < 0; i++) begin
      step(1'b1, 1'b1);
      if (rise) k = i;
    end
    chk("rst_wait_rise_edge", k, 6);
    do_reset();
    chk("toggle_init", int'(toggle), 0);
    for (int p = 1; p <= 3; p++) begin
      press();
`ifdef DEBOUNCE_TOGGLE_EN
      chk("toggle_after_press", int'(toggle), p % 2);
`else
      chk("toggle_after_press", int'(toggle), 0);
`endif
    end
    do_reset();
    begin
      bit v;
      v = 1'b0;
      for (int n = 0; n < 400; n++) begin
        int len;
        len = int'($urandom_range(1, 7));
        v = !v;
        if ($urandom_range(0, 49) == 0) step(1'b0, v);
        for (int i = 0; i < len; i++) step(1'b1, v);
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Purpose: upstream conditioner for the LED test stage. Turns a raw asynchronous switch or button input into a clean level, edge pulses and a press count.

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops (legal range 2..4).
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable samples needed to accept a change (legal range 1..65535).
REQ-003 Parameter CNT_W, default 4: press-counter width.
REQ-004 clk  input  1: single clock; all state updates on posedge.
REQ-005 resetn  input  1: synchronous reset, active-low.
REQ-006 in_raw  input  1: asynchronous raw button/switch level.
REQ-007 level  output  1: debounced level.
REQ-008 rise  output  1: one-cycle pulse on an accepted 0->1 change.
REQ-009 fall  output  1: one-cycle pulse on an accepted 1->0 change.
REQ-010 press_cnt  output  CNT_W: count of accepted rises.
REQ-011 toggle  output  1: flips on each accepted rise (see Configuration).

Function
REQ-012 in_raw shall pass through SYNC_STAGES flops; only the last stage (sync) is used by the logic.
REQ-013 FSM states: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO.
REQ-014 IDLE_LO: sync=1 -> WAIT_HI with stable counter = 1; otherwise stay.
REQ-015 WAIT_HI: sync=0 -> IDLE_LO with counter cleared. sync=1 with counter = DEBOUNCE_CYCLES -> IDLE_HI, level<=1, rise<=1. Otherwise counter+1.
REQ-016 IDLE_HI and WAIT_LO shall mirror REQ-014/015 with polarity inverted; acceptance drives level<=0 and fall<=1.
REQ-017 DEBOUNCE_CYCLES=1: the change is accepted on the first differing sample; the WAIT state is bypassed.
REQ-018 Latency: in_raw stable from edge t -> level updates at edge t+SYNC_STAGES+DEBOUNCE_CYCLES-1.
REQ-019 rise and fall are registered, high for exactly one cycle, coincident with the level change, and never both high.
REQ-020 Glitches shorter than DEBOUNCE_CYCLES samples shall produce no level change and no pulse.
REQ-021 press_cnt increments by 1 on each rise and wraps 2^CNT_W-1 -> 0 without saturation.
REQ-022 The stable counter width is sized from DEBOUNCE_CYCLES; the counter never overflows.

Reset
REQ-023 While resetn=0 at posedge: sync chain=0, state=IDLE_LO, counter=0, level=0, rise=0, fall=0, press_cnt=0, toggle=0.
REQ-024 Reset mid-WAIT abandons the pending change. If in_raw is high after release, a fresh debounce shall produce a rise.

Configuration
REQ-025 Macro DEBOUNCE_TOGGLE_EN defined: toggle is a register flipped on every rise; reset value 0.
REQ-026 Macro DEBOUNCE_TOGGLE_EN undefined: toggle is tied to 0 and no toggle flop exists. The port list is identical in both builds.

Structure
REQ-027 Package debounce_pkg holds the FSM state typedef and the default values of SYNC_STAGES, DEBOUNCE_CYCLES and CNT_W.
REQ-028 Sub-module sync_chain (parameter STAGES) implements the synchronizer; btn_debounce instantiates it once.

Verification
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, CNT_W=4.
REQ-029 in_raw 0->1 at edge 10, held -> level=1 and rise=1 at edge 15 only; press_cnt=1.
REQ-030 3-cycle high glitch on in_raw -> level, rise and fall remain 0 throughout; press_cnt=0.
REQ-031 17 clean press/release cycles -> press_cnt reads 15 then 0 then 1; fall pulses once per release.
REQ-032 resetn low for 1 cycle while in WAIT_HI with in_raw held high -> outputs 0 after the reset edge; rise 5 edges after release.
REQ-033 DEBOUNCE_TOGGLE_EN defined, 3 presses -> toggle 0->1->0->1. Undefined -> toggle stays 0.
